ula_result_stage: RTL and testbench

- Execute/writeback pipeline register directly downstream of the combinational 16-bit ALU.
- Captures the ALU result (Res) and flags (FlagReg [Z N V]) for the accepted instruction.
- Presents writebacks to the register-file port with a valid/ready handshake.
- Maintains the architectural status flags, resolves BEZ branches, and counts illegal ALU codes.

---
 rtl/ula_result_stage.sv | 119 +++++++++++
 tb/tb_ula_result_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_result_stage.sv
// Execute/writeback register behind the 16-bit ALU: holds the writeback, the architectural
// flags, the BEZ branch resolution and the illegal-opcode accounting.
module ula_result_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        CodeULA,
    input  logic [DATA_W-1:0] Res,
    input  logic [2:0]        FlagReg,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              flag_clr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              z_flag,
    output logic              n_flag,
    output logic              v_flag,
    output logic              v_sticky,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic [CNT_W-1:0]  illegal_cnt,
    output logic              err
);

    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_BEZ = 4'b0110;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic accept;
    logic is_write;
    logic is_arith;
    logic is_bez;
    logic do_write;
    logic do_bez;
    logic do_illegal;
    logic v_set;

    assign in_ready = ~wb_valid | wb_ready;
    assign accept   = in_valid & in_ready;

    assign is_write = (CodeULA <= OP_XOR);
    assign is_arith = (CodeULA <= OP_SUB);
    assign is_bez   = (CodeULA == OP_BEZ);

    // Every register enable is qualified by accept so garbage on the ALU bus is never captured.
    assign do_write   = accept & is_write;
    assign do_bez     = accept & is_bez;
    assign do_illegal = accept & ~is_write & ~is_bez;
    assign v_set      = do_write & is_arith & FlagReg[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
        end else if (do_write) begin
            wb_valid <= 1'b1;
            wb_data  <= Res;
            wb_addr  <= rd_addr;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            v_flag <= 1'b0;
        end else if (do_write) begin
            z_flag <= FlagReg[2];
            n_flag <= FlagReg[1];
            v_flag <= is_arith & FlagReg[0];
        end
    end

    // A new overflow in the same cycle as a clear request must not be lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_sticky <= 1'b0;
        end else if (v_set) begin
            v_sticky <= 1'b1;
        end else if (flag_clr) begin
            v_sticky <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_taken <= do_bez & FlagReg[2];
            if (do_bez) begin
                br_target <= Res;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            illegal_cnt <= '0;
            err         <= 1'b0;
        end else if (do_illegal) begin
            err <= 1'b1;
            if (illegal_cnt != CNT_MAX) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_result_stage.sv
// Bench for ula_result_stage: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a transaction-level model.
module tb_ula_result_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  CodeULA;
    logic [15:0] Res;
    logic [2:0]  FlagReg;
    logic [2:0]  rd_addr;
    logic        flag_clr;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_addr;
    logic        z_flag, n_flag, v_flag, v_sticky, br_taken, err;
    logic [15:0] br_target;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int failures = 0;

    ula_result_stage #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .CodeULA(CodeULA), .Res(Res), .FlagReg(FlagReg), .rd_addr(rd_addr),
        .flag_clr(flag_clr), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .z_flag(z_flag), .n_flag(n_flag),
        .v_flag(v_flag), .v_sticky(v_sticky), .br_taken(br_taken),
        .br_target(br_target), .illegal_cnt(illegal_cnt), .err(err)
    );

    always #5 CLK = ~CLK;

    // Transaction-level model: what the register file and branch unit must observe.
    logic        m_wb_valid;
    logic [15:0] m_wb_data;
    logic [2:0]  m_wb_addr;
    logic        m_z, m_n, m_v, m_vs, m_br, m_err;
    logic [15:0] m_br_target;
    int          m_cnt;
    logic        m_acc;

    assign m_acc = in_valid && (!m_wb_valid || wb_ready);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_wb_valid <= 0; m_wb_data <= 0; m_wb_addr <= 0;
            m_z <= 0; m_n <= 0; m_v <= 0; m_vs <= 0; m_br <= 0; m_br_target <= 0;
            m_cnt <= 0; m_err <= 0;
        end else begin
            m_br <= 0;
            if (m_wb_valid && wb_ready) m_wb_valid <= 0;
            if (m_acc) begin
                case (int'(CodeULA))
                    0, 1, 2, 3, 4, 5: begin
                        m_wb_valid <= 1;
                        m_wb_data  <= Res;
                        m_wb_addr  <= rd_addr;
                        m_z <= FlagReg[2];
                        m_n <= FlagReg[1];
                        m_v <= (int'(CodeULA) < 2) ? FlagReg[0] : 1'b0;
                    end
                    6: begin
                        m_br <= FlagReg[2];
                        m_br_target <= Res;
                    end
                    default: begin
                        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
                        m_err <= 1;
                    end
                endcase
            end
            if (m_acc && int'(CodeULA) < 2 && FlagReg[0]) m_vs <= 1;
            else if (flag_clr) m_vs <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            check("in_ready",    32'(in_ready),    32'(!m_wb_valid || wb_ready));
            check("wb_valid",    32'(wb_valid),    32'(m_wb_valid));
            check("wb_data",     32'(wb_data),     32'(m_wb_data));
            check("wb_addr",     32'(wb_addr),     32'(m_wb_addr));
            check("z_flag",      32'(z_flag),      32'(m_z));
            check("n_flag",      32'(n_flag),      32'(m_n));
            check("v_flag",      32'(v_flag),      32'(m_v));
            check("v_sticky",    32'(v_sticky),    32'(m_vs));
            check("br_taken",    32'(br_taken),    32'(m_br));
            if (m_br) check("br_target", 32'(br_target), 32'(m_br_target));
            check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
            check("err",         32'(err),         32'(m_err));
            if (br_taken && wb_valid && !m_wb_valid)
                check("br_wb_exclusive", 32'(wb_valid), 32'(0));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [3:0] code, input logic [15:0] r,
                           input logic [2:0] f, input logic [2:0] rd);
        in_valid = 1; CodeULA = code; Res = r; FlagReg = f; rd_addr = rd;
    endtask

    task automatic idle();
        in_valid = 0;
        CodeULA = 4'($urandom); Res = 16'($urandom); FlagReg = 3'($urandom);
        rd_addr = 3'($urandom);
    endtask

    initial begin
        RST = 1; in_valid = 0; CodeULA = 0; Res = 0; FlagReg = 0; rd_addr = 0;
        flag_clr = 0; wb_ready = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));

        // reset in the middle of a stalled writeback
        present(4'b0000, 16'h1234, 3'b000, 3'd5);
        tick();
        idle();
        check("stall_wb_valid", 32'(wb_valid), 32'(1));
        check("stall_wb_data",  32'(wb_data),  32'h1234);
        check("stall_wb_addr",  32'(wb_addr),  32'(5));
        repeat (3) tick();
        check("stall_in_ready", 32'(in_ready), 32'(0));
        RST = 1;
        #1;
        check("midrst_wb_valid", 32'(wb_valid), 32'(0));
        check("midrst_wb_data",  32'(wb_data),  32'(0));
        check("midrst_flags", 32'({z_flag, n_flag, v_flag, v_sticky}), 32'(0));
        tick();
        RST = 0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'(1));

        // back-to-back ADD then SUB with overflow
        wb_ready = 1;
        present(4'b0000, 16'h1111, 3'b000, 3'd1);
        tick();
        check("b2b_add_valid", 32'(wb_valid), 32'(1));
        check("b2b_add_data",  32'(wb_data),  32'h1111);
        present(4'b0001, 16'h7FFF, 3'b001, 3'd2);
        tick();
        idle();
        check("b2b_sub_valid", 32'(wb_valid), 32'(1));
        check("b2b_sub_data",  32'(wb_data),  32'h7FFF);
        check("sub_v_flag",    32'(v_flag),   32'(1));
        check("sub_v_sticky",  32'(v_sticky), 32'(1));
        check("sub_n_flag",    32'(n_flag),   32'(0));
        tick();
        check("drain_wb_valid", 32'(wb_valid), 32'(0));

        // logic op masks V; set beats clear
        present(4'b0011, 16'hF000, 3'b011, 3'd3);
        tick();
        check("and_v_flag", 32'(v_flag), 32'(0));
        check("and_n_flag", 32'(n_flag), 32'(1));
        present(4'b0000, 16'h0001, 3'b001, 3'd4);
        flag_clr = 1;
        tick();
        idle();
        check("set_wins_v_sticky", 32'(v_sticky), 32'(1));
        tick();
        flag_clr = 0;
        check("clr_v_sticky", 32'(v_sticky), 32'(0));

        // BEZ taken and not taken; z_flag currently 0
        present(4'b0110, 16'h0040, 3'b100, 3'd7);
        tick();
        idle();
        check("bez_taken",    32'(br_taken),  32'(1));
        check("bez_target",   32'(br_target), 32'h0040);
        check("bez_no_wb",    32'(wb_valid),  32'(0));
        check("bez_z_hold",   32'(z_flag),    32'(0));
        tick();
        check("bez_pulse_end", 32'(br_taken), 32'(0));
        present(4'b0110, 16'h0080, 3'b000, 3'd7);
        tick();
        idle();
        check("bez_nt", 32'(br_taken), 32'(0));

        // backpressure then release with XOR waiting
        wb_ready = 0;
        present(4'b0000, 16'hAAAA, 3'b000, 3'd4);
        tick();
        present(4'b0101, 16'h5555, 3'b000, 3'd6);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'(0));
        tick();
        check("bp_wb_data_hold", 32'(wb_data), 32'hAAAA);
        wb_ready = 1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'(1));
        tick();
        idle();
        check("bp_xor_valid", 32'(wb_valid), 32'(1));
        check("bp_xor_data",  32'(wb_data),  32'h5555);
        check("bp_xor_addr",  32'(wb_addr),  32'(6));
        tick();

        // illegal code saturation
        for (int i = 0; i < 260; i++) begin
            present(4'b1111, 16'($urandom), 3'b111, 3'($urandom));
            tick();
        end
        idle();
        tick();
        check("ill_cnt_sat", 32'(illegal_cnt), 32'(255));
        check("ill_err",     32'(err),         32'(1));
        check("ill_no_wb",   32'(wb_valid),    32'(0));
        check("ill_flags", 32'({z_flag, n_flag, v_flag}), 32'(0));

        // random traffic against the model
        RST = 1;
        tick();
        RST = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                present(4'($urandom_range(0, 3) == 0 ? $urandom_range(7, 15)
                                                      : $urandom_range(0, 6)),
                        16'($urandom), 3'($urandom), 3'($urandom));
            end else begin
                idle();
            end
            wb_ready = ($urandom_range(0, 2) != 0);
            flag_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        wb_ready = 1;
        flag_clr = 0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
